// File: rtl/tlc_phase_arbiter.sv
// tlc_phase_arbiter: round-robin intersection phase scheduler.
// Sequences green/yellow/all-red with timeouts and emergency preemption.
package tlc_pkg;
  typedef enum logic [1:0] {
    C_RED    = 2'd0,
    C_YELLOW = 2'd1,
    C_GREEN  = 2'd2
  } color_t;
endpackage

module tlc_phase_arbiter
  import tlc_pkg::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 9,
  parameter int VACANT_CYC = 4,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PHASES-1:0] req,
  input  logic                  preempt_req,
  input  logic [2:0]            preempt_phase,
  output logic [NUM_PHASES-1:0] grant,
  output color_t                phase_color,
  output logic [2:0]            active_phase,
  output logic [NUM_PHASES-1:0] pending,
  output logic                  all_red
);
  localparam int SEQ_MAX =
    (YELLOW_CYC > ALLRED_CYC) ? YELLOW_CYC : ALLRED_CYC;
  localparam int GW = $clog2(MAX_GREEN + 1);
  localparam int VW = $clog2(VACANT_CYC + 1);
  localparam int SW = $clog2(SEQ_MAX + 1);
  localparam logic [NUM_PHASES-1:0] ONE = NUM_PHASES'(1);

  typedef enum logic [1:0] {
    S_IDLE, S_GREEN, S_YELLOW, S_ALLRED
  } state_t;

  state_t state, state_d;
  logic [2:0] act_q, act_d, last_q, last_d;
  logic [2:0] sel, tgt, idx;
  logic [GW-1:0] gctr, gctr_d;
  logic [VW-1:0] vctr, vctr_d;
  logic [SW-1:0] sctr, sctr_d;
  logic [NUM_PHASES-1:0] cand, act_oh;
  logic [NUM_PHASES-1:0] pend_d, grant_d;
  logic pre_ok, own, other, found, go;
  logic all_red_d, max_hit, vac_hit;
  color_t color_d;

  assign cand   = pending | req;
  assign act_oh = ONE << act_q;
  assign own    = |(req & act_oh);
  assign other  = |(cand & ~act_oh);
  assign pre_ok = preempt_req &&
                  (int'(preempt_phase) < NUM_PHASES);

  // Rotating priority search starting just after the last served phase
  always_comb begin
    sel   = last_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      idx = 3'((int'(last_q) + k) % NUM_PHASES);
      if (!found && |(cand & (ONE << idx))) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign max_hit = (int'(gctr) + 1 >= MAX_GREEN) && other;
  assign vac_hit = !own && (int'(vctr) + 1 >= VACANT_CYC);

  always_comb begin
    state_d = state;
    act_d   = act_q;
    gctr_d  = gctr;
    vctr_d  = vctr;
    sctr_d  = sctr;
    go      = 1'b0;
    tgt     = sel;
    unique case (state)
      S_IDLE: begin
        if (pre_ok) begin
          go  = 1'b1;
          tgt = preempt_phase;
        end else if (|cand) begin
          go = 1'b1;
        end
      end
      S_GREEN: begin
        if (pre_ok && preempt_phase != act_q) begin
          state_d = S_YELLOW;
          sctr_d  = '0;
        end else if (pre_ok) begin
          gctr_d = '0;
          vctr_d = '0;
        end else begin
          gctr_d = (int'(gctr) < MAX_GREEN) ?
                   gctr + 1'b1 : gctr;
          vctr_d = own ? '0 :
                   (int'(vctr) < VACANT_CYC) ?
                   vctr + 1'b1 : vctr;
          if ((int'(gctr) + 1 >= MIN_GREEN) &&
              (max_hit || vac_hit)) begin
            state_d = S_YELLOW;
            sctr_d  = '0;
          end
        end
      end
      S_YELLOW: begin
        if (int'(sctr) + 1 >= YELLOW_CYC) begin
          state_d = S_ALLRED;
          sctr_d  = '0;
        end else begin
          sctr_d = sctr + 1'b1;
        end
      end
      S_ALLRED: begin
        if (int'(sctr) + 1 >= ALLRED_CYC) begin
          sctr_d = '0;
          if (pre_ok) begin
            go  = 1'b1;
            tgt = preempt_phase;
          end else if (|cand) begin
            go = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          sctr_d = sctr + 1'b1;
        end
      end
    endcase
    if (go) begin
      state_d = S_GREEN;
      act_d   = tgt;
      gctr_d  = '0;
      vctr_d  = '0;
    end
    last_d = go ? tgt : last_q;
    // A clear on green entry wins over a same-edge set
    pend_d = (pending |
              (req & ~((state == S_GREEN) ? act_oh : '0))) &
             ~(go ? (ONE << tgt) : '0);
  end

  always_comb begin
    grant_d   = '0;
    color_d   = C_RED;
    all_red_d = 1'b1;
    unique case (state_d)
      S_GREEN: begin
        grant_d   = ONE << act_d;
        color_d   = C_GREEN;
        all_red_d = 1'b0;
      end
      S_YELLOW: begin
        grant_d   = ONE << act_d;
        color_d   = C_YELLOW;
        all_red_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      act_q       <= '0;
      last_q      <= 3'(NUM_PHASES - 1);
      gctr        <= '0;
      vctr        <= '0;
      sctr        <= '0;
      pending     <= '0;
      grant       <= '0;
      phase_color <= C_RED;
      all_red     <= 1'b1;
    end else begin
      state       <= state_d;
      act_q       <= act_d;
      last_q      <= last_d;
      gctr        <= gctr_d;
      vctr        <= vctr_d;
      sctr        <= sctr_d;
      pending     <= pend_d;
      grant       <= grant_d;
      phase_color <= color_d;
      all_red     <= all_red_d;
    end
  end

  assign active_phase = act_q;
endmodule
